// File: rtl/jtkiwi_lbuf_scan.sv
// Double-banked line buffer: the tile engine draws into one bank while the scan reads the other.
// Optional macro JTKIWI_LBUF_ERASE_EN clears each pixel after it is scanned.
module jtkiwi_lbuf_scan #(
  parameter int DW = 9,
  parameter int AW = 9
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          pxl_cen,
  input  logic          hs,
  input  logic          LHBL,
  input  logic [AW-1:0] hdump,
  input  logic [AW-1:0] buf_addr,
  input  logic          buf_we,
  input  logic [DW-1:0] buf_din,
  output logic          wr_bank,
  output logic [DW-1:0] pxl
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];

  logic          hs_q;
  logic          wr_bank_q, wr_bank_d;
  logic          valid_q;
  logic [DW-1:0] ram_q;

  logic          draw_we;
  logic          erase_we;
  logic [AW-1:0] erase_addr;
  logic          erase_bank;

  logic          we0, we1;
  logic [AW-1:0] waddr0, waddr1;
  logic [DW-1:0] wdata0, wdata1;

  // The hs rising cycle still writes to the old bank; the new bank takes effect next cycle.
  always_comb wr_bank_d = wr_bank_q ^ (hs & ~hs_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q      <= 1'b0;
      wr_bank_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      hs_q      <= hs;
      wr_bank_q <= wr_bank_d;
      if (pxl_cen) valid_q <= LHBL;
    end
  end

  // Pixels with colour index 0 are transparent and leave the buffer untouched.
  assign draw_we = buf_we & (buf_din[3:0] != 4'd0) & ~rst;

`ifdef JTKIWI_LBUF_ERASE_EN
  logic          erase_q;
  logic [AW-1:0] erase_addr_q;
  logic          erase_bank_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      erase_q      <= 1'b0;
      erase_addr_q <= '0;
      erase_bank_q <= 1'b0;
    end else begin
      erase_q <= pxl_cen & LHBL;
      if (pxl_cen) begin
        erase_addr_q <= hdump;
        erase_bank_q <= ~wr_bank_q;
      end
    end
  end

  // A bank that has just become the write bank is owned by the draw path, so the erase is skipped.
  assign erase_we   = erase_q & (erase_bank_q != wr_bank_q) & ~rst;
  assign erase_addr = erase_addr_q;
  assign erase_bank = erase_bank_q;
`else
  assign erase_we   = 1'b0;
  assign erase_addr = '0;
  assign erase_bank = 1'b0;
`endif

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    we0    = 1'b0;
    we1    = 1'b0;
    waddr0 = buf_addr;
    waddr1 = buf_addr;
    wdata0 = buf_din;
    wdata1 = buf_din;
    if (draw_we) begin
      if (wr_bank_q) we1 = 1'b1;
      else           we0 = 1'b1;
    end
    if (erase_we) begin
      if (erase_bank) begin
        we1    = 1'b1;
        waddr1 = erase_addr;
        wdata1 = '0;
      end else begin
        we0    = 1'b1;
        waddr0 = erase_addr;
        wdata0 = '0;
      end
    end
  end

  // NOTE: the RAM arrays and their read register have no reset, so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (we0) mem0[waddr0] <= wdata0;
    if (we1) mem1[waddr1] <= wdata1;
    if (pxl_cen) ram_q <= wr_bank_q ? mem0[hdump] : mem1[hdump];
  end

  assign wr_bank = wr_bank_q;
  assign pxl     = valid_q ? ram_q : '0;

endmodule

// File: tb/tb_jtkiwi_lbuf_scan.sv
// Directed bench for jtkiwi_lbuf_scan: draw/scan, transparency, blanking, erase, bank swap and reset.
module tb_jtkiwi_lbuf_scan;

  localparam int DW = 9;
  localparam int AW = 9;

`ifdef JTKIWI_LBUF_ERASE_EN
  localparam logic [DW-1:0] ERASED = 9'h000;
`else
  localparam logic [DW-1:0] ERASED = 9'h155;
`endif

  logic          rst = 1'b1;
  logic          clk = 1'b0;
  logic          pxl_cen = 1'b0;
  logic          hs = 1'b0;
  logic          LHBL = 1'b0;
  logic [AW-1:0] hdump = '0;
  logic [AW-1:0] buf_addr = '0;
  logic          buf_we = 1'b0;
  logic [DW-1:0] buf_din = '0;
  logic          wr_bank;
  logic [DW-1:0] pxl;

  int errors = 0;
  int checks = 0;

  jtkiwi_lbuf_scan #(.DW(DW), .AW(AW)) dut (
    .rst     (rst),
    .clk     (clk),
    .pxl_cen (pxl_cen),
    .hs      (hs),
    .LHBL    (LHBL),
    .hdump   (hdump),
    .buf_addr(buf_addr),
    .buf_we  (buf_we),
    .buf_din (buf_din),
    .wr_bank (wr_bank),
    .pxl     (pxl)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic draw(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    buf_addr = addr;
    buf_din  = data;
    buf_we   = 1'b1;
    step();
    buf_we   = 1'b0;
  endtask

  task automatic swap();
    hs = 1'b1;
    step();
    hs = 1'b0;
    step();
  endtask

  task automatic scan(input logic [AW-1:0] addr, input logic lhbl);
    hdump   = addr;
    LHBL    = lhbl;
    pxl_cen = 1'b1;
    step();
    pxl_cen = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("reset_wr_bank", 9'(wr_bank), 9'h000);
    chk("reset_pxl", pxl, 9'h000);
    rst = 1'b0;
    step();

    // draw then scan
    draw(9'h010, 9'h1A5);
    chk("draw_wr_bank0", 9'(wr_bank), 9'h000);
    swap();
    chk("swap_wr_bank1", 9'(wr_bank), 9'h001);
    scan(9'h010, 1'b1);
    chk("draw_scan", pxl, 9'h1A5);
    hdump = 9'h000;
    step();
    chk("pxl_hold", pxl, 9'h1A5);

    // transparent skip
    draw(9'h020, 9'h1A5);
    draw(9'h020, 9'h1E0);
    swap();
    scan(9'h020, 1'b1);
    chk("transparent_skip", pxl, 9'h1A5);

    // blank
    draw(9'h050, 9'h0F3);
    swap();
    scan(9'h050, 1'b0);
    chk("blank_pxl", pxl, 9'h000);
    scan(9'h050, 1'b1);
    chk("unblank_pxl", pxl, 9'h0F3);

    // erase after scan
    draw(9'h030, 9'h155);
    swap();
    scan(9'h030, 1'b1);
    chk("erase_first_read", pxl, 9'h155);
    step();
    swap();
    swap();
    scan(9'h030, 1'b1);
    chk("erase_second_read", pxl, ERASED);

    // swap collision and write burst across the toggle
    chk("collision_pre_bank", 9'(wr_bank), 9'h000);
    hs       = 1'b1;
    buf_addr = 9'h040;
    buf_din  = 9'h1B7;
    buf_we   = 1'b1;
    step();
    hs       = 1'b0;
    buf_addr = 9'h041;
    buf_din  = 9'h1C2;
    step();
    buf_we   = 1'b0;
    chk("collision_wr_bank", 9'(wr_bank), 9'h001);
    scan(9'h040, 1'b1);
    chk("collision_old_bank", pxl, 9'h1B7);
    swap();
    scan(9'h041, 1'b1);
    chk("burst_new_bank", pxl, 9'h1C2);

    // top address and reset mid-line
    draw(9'h1FF, 9'h1DD);
    draw(9'h070, 9'h1AA);
    swap();
    scan(9'h1FF, 1'b1);
    chk("top_addr", pxl, 9'h1DD);
    rst      = 1'b1;
    buf_addr = 9'h070;
    buf_din  = 9'h1EE;
    buf_we   = 1'b1;
    pxl_cen  = 1'b1;
    #1;
    chk("rst_pxl_async", pxl, 9'h000);
    chk("rst_wr_bank_async", 9'(wr_bank), 9'h000);
    step();
    chk("rst_pxl_cycle", pxl, 9'h000);
    chk("rst_wr_bank_cycle", 9'(wr_bank), 9'h000);
    rst     = 1'b0;
    buf_we  = 1'b0;
    pxl_cen = 1'b0;
    step();
    swap();
    chk("post_rst_wr_bank", 9'(wr_bank), 9'h001);
    scan(9'h070, 1'b1);
    chk("no_write_in_rst", pxl, 9'h1AA);
    scan(9'h1FF, 1'b1);
    chk("erase_aborted", pxl, 9'h1DD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtkiwi_lbuf_scan.md
JTKIWI_LBUF_SCAN -- requirements
Module: jtkiwi_lbuf_scan

Interface
REQ-001 SHALL have parameter DW, default 9: line buffer word width, {pal[4:0], pxl[3:0]}.
REQ-002 SHALL have parameter AW, default 9: line buffer address width, giving 512 entries per bank.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port pxl_cen, input, 1 bit: pixel clock enable.
REQ-006 SHALL have port hs, input, 1 bit: horizontal sync; its rising edge swaps banks.
REQ-007 SHALL have port LHBL, input, 1 bit: active-low horizontal blank.
REQ-008 SHALL have port hdump, input, AW bits: scan read address.
REQ-009 SHALL have port buf_addr, input, AW bits: tile draw engine write address.
REQ-010 SHALL have port buf_we, input, 1 bit: tile draw engine write strobe.
REQ-011 SHALL have port buf_din, input, DW bits: tile draw engine write data.
REQ-012 SHALL have port wr_bank, output, 1 bit: bank currently receiving draw writes.
REQ-013 SHALL have port pxl, output, DW bits: registered scan pixel.

Function
REQ-014 SHALL contain two banks of 2^AW x DW synchronous RAM; read bank = ~wr_bank, write bank = wr_bank.
REQ-015 SHALL register hs every clk; a 0->1 transition toggles wr_bank in the following cycle.
REQ-016 SHALL write buf_din to buf_addr of the write bank when buf_we=1 and buf_din[3:0]!=0; SHALL drop writes with buf_din[3:0]==0 (transparent).
REQ-017 SHALL direct a write coinciding with the hs toggle cycle to the bank selected before the toggle.
REQ-018 SHALL present hdump to the read bank on a cycle where pxl_cen=1 (read cycle R).
REQ-019 SHALL load pxl from RAM at cycle R+1 when LHBL was 1 at R; SHALL load pxl=0 when LHBL was 0 at R.
REQ-020 SHALL hold pxl between loads.
REQ-021 SHALL never share a bank between the write path and the read/erase path in the same cycle.
REQ-022 SHALL keep buf_addr within AW bits; writes past 2^AW-1 wrap to 0, as the draw engine's address counter does.
REQ-023 SHALL let buf_we active across a bank toggle continue into the new write bank without loss; the old bank's data is not corrupted.

Reset
REQ-024 SHALL clear, while rst=1: wr_bank=0, pxl=0, hs history=0, erase pipeline idle.
REQ-025 SHALL NOT clear RAM contents on reset; the first line after reset displays undefined data unless erase was active during the preceding scan.
REQ-026 SHALL abort a pending erase when rst asserts mid-line, leaving the location unerased.

Configuration
REQ-027 SHALL use macro JTKIWI_LBUF_ERASE_EN.
REQ-028 With JTKIWI_LBUF_ERASE_EN defined: at cycle R+1 of every read with LHBL=1, SHALL write 0 to the same address in the read bank, so the bank is blank when it next becomes the write bank.
REQ-029 Without JTKIWI_LBUF_ERASE_EN: SHALL perform no erase writes; RAM read ports are pure reads and the draw engine must overwrite every pixel each line.

Verification
REQ-030 SHALL pass test "draw then scan": write bank 0 addr 0x010 data 0x1A5, pulse hs, read hdump=0x010 with LHBL=1 -> pxl=0x1A5 one clk after the pxl_cen cycle.
REQ-031 SHALL pass test "transparent skip": write 0x1A5 then 0x1E0 to addr 0x020, swap, read 0x020 -> pxl=0x1A5.
REQ-032 SHALL pass test "blank": LHBL=0 during read of a location holding 0x0F3 -> pxl=0.
REQ-033 SHALL pass test "erase" (ERASE_EN): read 0x030 (0x155) in bank 1, swap twice, read 0x030 again -> pxl=0; without ERASE_EN -> pxl=0x155.
REQ-034 SHALL pass test "swap collision": buf_we at 0x040 in the same cycle hs rises -> data lands in the old bank, readable on the next line.
REQ-035 SHALL pass test "reset mid-line": assert rst during the active scan -> pxl=0 and wr_bank=0 the next cycle; no write occurs during rst.
